tipi_mailbox: RTL
=================

# tipi_mailbox

Clocked, parametrised TI-99/4A-to-Raspberry-Pi mailbox for the TIPI CPLD/FPGA. It synchronises the TI bus into the `clk` domain and decodes `CHANNELS` write-latch registers at the top of the DSR window. It presents latched bytes to the RPi with valid/strobe/ack handshaking, per-channel overrun detection and read notification. It also holds the CRU device-enable bit and drives the transceiver/DSR output enables.

## Interface
Parameters:
- `CHANNELS`, 2 — number of mailbox channels, 1..4.
- `TOP_ADDR`, 16'h5fff — address of the channel-0 write register.
- `SYNC_STAGES`, 2 — flip-flop stages on every TI input, minimum 2.

Ports:
- `clk` in 1 — 50 MHz system clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `ti_a` in [0:15] — TI address bus; bit 0 is the MSB.
- `ti_data` in [0:7] — TI data bus; bit 0 is the MSB.
- `ti_memen`, `ti_we`, `ti_cruclk`, `ti_reset` in 1 each — all active low.
- `ti_dbin` in 1 — active high.
- `cru_base` in 4 — CRU base nibble n, for base address 0x1n00.
- `crubit` out 1 — device enable.
- `rd_oe_n` out CHANNELS — per-channel RPi→TI readback transceiver enable, active low.
- `dsr_oe_n` out 1 — DSR ROM output enable, active low.
- `tx_data` out 8*CHANNELS — latched byte; channel k occupies [8k+7:8k].
- `tx_valid` out CHANNELS — a byte is pending for the RPi.
- `tx_strobe` out CHANNELS — one-clk pulse on each accepted write.
- `tx_ack` in CHANNELS — RPi consumed the byte; level or pulse, sampled each clk.
- `tx_overrun` out CHANNELS — sticky flag: a write arrived while `tx_valid` was still set.
- `rd_strobe` out CHANNELS — one-clk pulse at the end of a TI read of readback k.

## Operation
- **Address map**
  - Write register k is at `TOP_ADDR - 2k`.
  - Readback register k is at `TOP_ADDR - 2*CHANNELS - 2k`.
  - With the defaults this gives writes at 0x5fff/0x5ffd and readbacks at 0x5ffb/0x5ff9.
  - The DSR region is 0x4000 up to (lowest mailbox address - 1) inclusive.
- **Output enables**
  - `rd_oe_n[k]` and `dsr_oe_n` are combinational from the raw pins, for transceiver timing.
  - Each is low only when `crubit` & ~`ti_memen` & `ti_dbin` & the address matches.
  - These are the only unsynchronised paths.
- **Synchronised inputs**
  - All other logic uses synchronised copies: `s_a`, `s_data`, `s_we`, `s_memen`, `s_dbin`, `s_cruclk`, `s_reset`.
  - One extra register holds the previous `s_we`, `s_cruclk` and `s_dbin` for edge detection.
- **Write accept**
  - Condition: `s_we` falling edge & ~`s_memen` & `crubit` & `s_a` equals write address k.
  - On accept: `tx_data[k]` <= `s_data`, `tx_valid[k]` <= 1, and `tx_strobe[k]` pulses.
  - If `tx_valid[k]` was already 1 and `tx_ack[k]` is not asserted in that cycle, `tx_overrun[k]` <= 1.
- **Acknowledge**
  - `tx_ack[k]` clears `tx_valid[k]` and `tx_overrun[k]`.
  - If an ack and an accept happen in the same cycle, the accept wins: valid=1, overrun unchanged-cleared (0), data is new.
- **Read notify**
  - `rd_strobe[k]` pulses on the `s_dbin` falling edge when the previous cycle had ~`s_memen` & `crubit` & `s_a` equal to readback address k.
- **CRU**
  - Decode on the `s_cruclk` falling edge: `s_a[0:3]`=4'b0001, `s_a[4:7]`=`cru_base`, `s_a[8:14]`=0.
  - On a match, `crubit` <= `s_a[15]`.
  - While `crubit`=0, no write, read or OE activity occurs. Existing `tx_valid` is retained.
- **TI reset**
  - `s_reset`=0 acts as a synchronous clear: `crubit`, `tx_valid`, `tx_overrun` and `tx_data` go to 0.
  - This clear overrides any same-cycle accept or CRU write.
- **Async reset** (`rst_n`=0): all outputs go to 0, except `rd_oe_n` and `dsr_oe_n`, which stay combinational and read 1 because `crubit`=0. Synchroniser chains reset to idle values: we/memen/cruclk/reset = 1, dbin = 0.

## Timing
- Pin edge to state update: SYNC_STAGES+1 clk (3 with the defaults). `tx_valid` rises in the same cycle as `tx_strobe`.
- `tx_ack` to `tx_valid`=0: 1 clk.
- TI write strobe is ≥ 8 clk wide at 50 MHz, so no edge is lost. Address and data are stable across the we-low period and pass through the same stage count, so they stay aligned with the edge.
- Back-to-back TI writes to the same channel without an ack: both accepted, the last data is retained, overrun is set.
- `rst_n` deassertion is synchronised externally. The block assumes release is synchronous to `clk`.

## Structure
- Package `tipi_bus_pkg`:
  - `DSR_BASE` = 16'h4000.
  - CRU prefix constant 4'b0001.
  - Functions `wr_addr(k)`, `rd_addr(k)` and `cru_match(a, base)`.
- Sub-module `tipi_sync #(WIDTH, STAGES, RESET_VAL)`: multi-bit flop chain with asynchronous reset, instantiated once per signal group.
- Per-channel logic sits in a generate loop. No memories are inferred.

## Test plan
- CRU enable, then write: drive a CRU cycle with address 0x1100 and A15=1 (`cru_base`=1), then a TI write of 0xA5 to 0x5fff. Required: `tx_data[7:0]`=0xA5, one `tx_strobe[0]` pulse, `tx_valid[0]`=1 three clk after we falls.
- Disabled device: write 0x3C to 0x5ffd with `crubit`=0. Required: no strobe, `tx_valid[1]`=0, `tx_data[15:8]` unchanged.
- Overrun: two writes to 0x5fff (0x11 then 0x22) with no ack. Required: data 0x22 and `tx_overrun[0]`=1. An ack then clears both flags in 1 clk.
- Ack/write collision: `tx_ack[0]` asserted in the accept cycle. Required: `tx_valid[0]`=1 and `tx_overrun[0]`=0.
- Readback and OE: TI read of 0x5ff9 while enabled. Required: `rd_oe_n[1]` low while memen/dbin are active, then one `rd_strobe[1]` pulse after dbin falls. A read of 0x5000 drives `dsr_oe_n` low instead.
- Reset mid-transfer: `ti_reset` pulses low with `tx_valid`=2'b11. Required: all flags and `crubit` are 0. Asserting `rst_n` low mid-write forces all outputs to their reset values with no strobe.

Source files
------------

// File: rtl/tipi_bus_pkg.sv
// Shared TI-99/4A bus constants and address helpers for the TIPI mailbox.
// Addresses are plain 16-bit values, MSB first, matching TI A0..A15.
package tipi_bus_pkg;

    localparam logic [15:0] DSR_BASE   = 16'h4000;
    localparam logic [3:0]  CRU_PREFIX = 4'b0001;

    // Write register k sits 2k below the top of the DSR window.
    function automatic logic [15:0] wr_addr(input logic [15:0] top, input int unsigned k);
        return top - 16'(2 * k);
    endfunction

    // Readback registers follow directly below the block of write registers.
    function automatic logic [15:0] rd_addr(input logic [15:0] top, input int unsigned chans,
                                            input int unsigned k);
        return top - 16'(2 * chans) - 16'(2 * k);
    endfunction

    // CRU bit address 0x1n00/0x1n01: prefix, base nibble, zero middle bits; A15 is the data.
    function automatic logic cru_match(input logic [15:0] a, input logic [3:0] base);
        return (a[15:12] == CRU_PREFIX) && (a[11:8] == base) && (a[7:1] == 7'd0);
    endfunction

endpackage

// File: rtl/tipi_mailbox_if.sv
// TI-bus and RPi-side signal bundle for the TIPI mailbox.
// The master side drives the TI pins and acks; the slave side is the mailbox itself.
interface tipi_mailbox_if #(
    parameter int unsigned CHANNELS = 2
);

    logic [0:15]             ti_a;
    logic [0:7]              ti_data;
    logic                    ti_memen;
    logic                    ti_we;
    logic                    ti_cruclk;
    logic                    ti_reset;
    logic                    ti_dbin;
    logic [3:0]              cru_base;

    logic                    crubit;
    logic [CHANNELS-1:0]     rd_oe_n;
    logic                    dsr_oe_n;

    logic [8*CHANNELS-1:0]   tx_data;
    logic [CHANNELS-1:0]     tx_valid;
    logic [CHANNELS-1:0]     tx_strobe;
    logic [CHANNELS-1:0]     tx_ack;
    logic [CHANNELS-1:0]     tx_overrun;
    logic [CHANNELS-1:0]     rd_strobe;

    modport master (
        output ti_a, ti_data, ti_memen, ti_we, ti_cruclk, ti_reset, ti_dbin, cru_base, tx_ack,
        input  crubit, rd_oe_n, dsr_oe_n, tx_data, tx_valid, tx_strobe, tx_overrun, rd_strobe
    );

    modport slave (
        input  ti_a, ti_data, ti_memen, ti_we, ti_cruclk, ti_reset, ti_dbin, cru_base, tx_ack,
        output crubit, rd_oe_n, dsr_oe_n, tx_data, tx_valid, tx_strobe, tx_overrun, rd_strobe
    );

endinterface

// File: rtl/tipi_sync.sv
// Multi-bit flop chain bringing asynchronous TI pins into the clk domain.
// Reset loads the idle (inactive) level so no spurious edges appear on release.
module tipi_sync #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/tipi_mailbox.sv
// TI-99/4A to Raspberry Pi mailbox: latches TI writes per channel, hands them to the RPi
// with valid/strobe/ack, flags overruns, notifies readback reads and holds the CRU enable.
module tipi_mailbox
    import tipi_bus_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter logic [15:0] TOP_ADDR    = 16'h5fff,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    tipi_mailbox_if.slave bus_io
);

    localparam logic [15:0] DsrLast = rd_addr(TOP_ADDR, CHANNELS, CHANNELS - 1) - 16'd1;

    logic [0:15] s_a;
    logic [0:7]  s_data;
    logic [3:0]  s_ctrl;
    logic        s_we, s_memen, s_cruclk, s_reset, s_dbin;

    tipi_sync #(
        .WIDTH     (16),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (16'h0000)
    ) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus_io.ti_a),
        .q_o   (s_a)
    );

    tipi_sync #(
        .WIDTH     (8),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (8'h00)
    ) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus_io.ti_data),
        .q_o   (s_data)
    );

    // Active-low strobes idle high.
    tipi_sync #(
        .WIDTH     (4),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (4'b1111)
    ) u_sync_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({bus_io.ti_we, bus_io.ti_memen, bus_io.ti_cruclk, bus_io.ti_reset}),
        .q_o   (s_ctrl)
    );

    tipi_sync #(
        .WIDTH     (1),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_dbin (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus_io.ti_dbin),
        .q_o   (s_dbin)
    );

    assign s_we     = s_ctrl[3];
    assign s_memen  = s_ctrl[2];
    assign s_cruclk = s_ctrl[1];
    assign s_reset  = s_ctrl[0];

    logic we_prev_q, cruclk_prev_q, dbin_prev_q;
    logic we_fall, cruclk_fall, dbin_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_prev_q     <= 1'b1;
            cruclk_prev_q <= 1'b1;
            dbin_prev_q   <= 1'b0;
        end else begin
            we_prev_q     <= s_we;
            cruclk_prev_q <= s_cruclk;
            dbin_prev_q   <= s_dbin;
        end
    end

    assign we_fall     = we_prev_q & ~s_we;
    assign cruclk_fall = cruclk_prev_q & ~s_cruclk;
    assign dbin_fall   = dbin_prev_q & ~s_dbin;

    logic crubit_q, crubit_d;

    // TI reset beats a same-cycle CRU write.
    always_comb begin
        crubit_d = crubit_q;
        if (!s_reset) begin
            crubit_d = 1'b0;
        end else if (cruclk_fall && cru_match(s_a, bus_io.cru_base)) begin
            crubit_d = s_a[15];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crubit_q <= 1'b0;
        end else begin
            crubit_q <= crubit_d;
        end
    end

    logic [8*CHANNELS-1:0] data_vec;
    logic [CHANNELS-1:0]   valid_vec, ovr_vec, stb_vec, rd_stb_vec, rd_oe_vec;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        localparam logic [15:0] WrAddr = wr_addr(TOP_ADDR, k);
        localparam logic [15:0] RdAddr = rd_addr(TOP_ADDR, CHANNELS, k);

        logic       accept, ack, rd_hit;
        logic [7:0] data_q, data_d;
        logic       valid_q, valid_d;
        logic       ovr_q, ovr_d;
        logic       stb_q, rd_hit_q, rd_stb_q, rd_stb_d;

        assign ack    = bus_io.tx_ack[k];
        assign accept = s_reset & we_fall & ~s_memen & crubit_q & (s_a == WrAddr);
        assign rd_hit = ~s_memen & crubit_q & (s_a == RdAddr);

        // Accept beats ack; an ack in the accept cycle still suppresses the overrun.
        always_comb begin
            data_d   = data_q;
            valid_d  = valid_q;
            ovr_d    = ovr_q;
            rd_stb_d = dbin_fall & rd_hit_q;
            if (!s_reset) begin
                data_d  = 8'h00;
                valid_d = 1'b0;
                ovr_d   = 1'b0;
            end else if (accept) begin
                data_d  = s_data;
                valid_d = 1'b1;
                ovr_d   = ~ack & (ovr_q | valid_q);
            end else if (ack) begin
                valid_d = 1'b0;
                ovr_d   = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q   <= 8'h00;
                valid_q  <= 1'b0;
                ovr_q    <= 1'b0;
                stb_q    <= 1'b0;
                rd_hit_q <= 1'b0;
                rd_stb_q <= 1'b0;
            end else begin
                data_q   <= data_d;
                valid_q  <= valid_d;
                ovr_q    <= ovr_d;
                stb_q    <= accept;
                rd_hit_q <= rd_hit;
                rd_stb_q <= rd_stb_d;
            end
        end

        assign data_vec[8*k +: 8] = data_q;
        assign valid_vec[k]       = valid_q;
        assign ovr_vec[k]         = ovr_q;
        assign stb_vec[k]         = stb_q;
        assign rd_stb_vec[k]      = rd_stb_q;
        // Raw pins here: the transceiver must turn on within the TI read cycle.
        assign rd_oe_vec[k]       = ~(crubit_q & ~bus_io.ti_memen & bus_io.ti_dbin &
                                      (bus_io.ti_a == RdAddr));
    end

    assign bus_io.crubit     = crubit_q;
    assign bus_io.tx_data    = data_vec;
    assign bus_io.tx_valid   = valid_vec;
    assign bus_io.tx_overrun = ovr_vec;
    assign bus_io.tx_strobe  = stb_vec;
    assign bus_io.rd_strobe  = rd_stb_vec;
    assign bus_io.rd_oe_n    = rd_oe_vec;
    assign bus_io.dsr_oe_n   = ~(crubit_q & ~bus_io.ti_memen & bus_io.ti_dbin &
                                 (bus_io.ti_a >= DSR_BASE) && (bus_io.ti_a <= DsrLast));

endmodule
